// File: rtl/lsu_mem_if.sv
// Data-memory channel between an LSU lane and memory: independent read and write request/ready pairs.
// The master drives valid, address and data, and the slave answers with ready (and read data).
interface lsu_mem_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/lsu_param.sv
// Per-lane load/store unit: LDR/STR at rs+imm over a valid/ready channel, with bounded wait and error flag.
// Latency is 3 edges minimum from REQUEST to DONE; valid is held until ready or timeout, and enable=0 freezes everything.
module lsu_param #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int IMM_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [ADDR_BITS-1:0] rs,
  input  logic [IMM_BITS-1:0]  imm,
  input  logic [DATA_BITS-1:0] rt,
  lsu_mem_if.master            mem,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // A zero timeout still needs a legal one-bit counter; the compare is gated off.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]           r_state;
  logic                 r_is_store;
  logic [CW-1:0]        r_cnt;
  logic [DATA_BITS-1:0] r_out;
  logic                 r_err;
  logic                 r_rd_vld;
  logic [ADDR_BITS-1:0] r_rd_addr;
  logic                 r_wr_vld;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [DATA_BITS-1:0] r_wr_dat;

  logic [ADDR_BITS-1:0] w_addr;
  logic [CW-1:0]        w_cnt_inc;
  logic                 w_timeout;

  assign w_addr    = rs + ADDR_BITS'($signed(imm));
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_err      <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_vld   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_dat   <= '0;
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          if (core_state == CORE_REQUEST) begin
            if (decoded_mem_read_enable && decoded_mem_write_enable) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (decoded_mem_read_enable ^ decoded_mem_write_enable) begin
              r_is_store <= decoded_mem_write_enable;
              r_state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_cnt <= '0;
          if (r_is_store) begin
            r_wr_vld  <= 1'b1;
            r_wr_addr <= w_addr;
            r_wr_dat  <= rt;
          end else begin
            r_rd_vld  <= 1'b1;
            r_rd_addr <= w_addr;
          end
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Ready is checked before the timeout so a same-edge ready completes cleanly.
          if (!r_is_store && mem.mem_read_ready) begin
            r_out    <= mem.mem_read_data;
            r_rd_vld <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_is_store && mem.mem_write_ready) begin
            r_wr_vld <= 1'b0;
            r_state  <= S_DONE;
          end else if (w_timeout) begin
            r_rd_vld <= 1'b0;
            r_wr_vld <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          if (core_state == CORE_UPDATE) begin
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_read_valid    = r_rd_vld;
  assign mem.mem_read_address  = r_rd_addr;
  assign mem.mem_write_valid   = r_wr_vld;
  assign mem.mem_write_address = r_wr_addr;
  assign mem.mem_write_data    = r_wr_dat;
  assign lsu_state             = r_state;
  assign lsu_out               = r_out;
  assign lsu_error             = r_err;

endmodule

// File: tb/tb_lsu_param.sv
// Scenario bench for lsu_param with TIMEOUT_CYCLES=4; expected transactions queued at issue and checked at DONE.
module tb_lsu_param;

  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] UPDATE  = 3'b110;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [2:0] core_state = 3'b000;
  logic       rd_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] rs = 8'h00;
  logic [3:0] imm = 4'h0;
  logic [7:0] rt = 8'h00;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       err;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  lsu_mem_if #(.ADDR_BITS(8), .DATA_BITS(8)) mem ();

  lsu_param #(.ADDR_BITS(8), .DATA_BITS(8), .IMM_BITS(4), .TIMEOUT_CYCLES(4)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .imm                      (imm),
    .rt                       (rt),
    .mem                      (mem),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out),
    .lsu_error                (lsu_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request in IDLE; returns one edge later with the LSU in REQUESTING.
  task automatic issue(input logic r, input logic w, input logic [7:0] a,
                       input logic [3:0] i, input logic [7:0] d);
    rd_en = r; wr_en = w; rs = a; imm = i; rt = d;
    core_state = REQUEST;
    tick();
    core_state = 3'b000; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_update();
    core_state = UPDATE;
    tick();
    core_state = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (lsu_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", lsu_state); end
    checks++; if (lsu_out !== 8'h00) begin errors++; $display("FAIL reset_out got=%0h exp=00", lsu_out); end
    checks++; if (lsu_error !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", lsu_error); end
    checks++; if ({mem.mem_read_valid, mem.mem_write_valid} !== 2'b00) begin errors++;
      $display("FAIL reset_valids got=%b exp=00", {mem.mem_read_valid, mem.mem_write_valid}); end
    checks++; if ({mem.mem_read_address, mem.mem_write_address, mem.mem_write_data} !== 24'h0) begin errors++;
      $display("FAIL reset_bus got=%h exp=000000", {mem.mem_read_address, mem.mem_write_address, mem.mem_write_data}); end
  endtask

  task automatic test_load();
    sb.push_back('{addr: 8'h13, data: 8'hA5, err: 1'b0});
    issue(1'b1, 1'b0, 8'h10, 4'h3, 8'h00);
    checks++; if (lsu_state !== 2'd1 || mem.mem_read_valid !== 1'b0) begin errors++;
      $display("FAIL load_requesting state=%0d vld=%b exp state=1 vld=0", lsu_state, mem.mem_read_valid); end
    tick();
    checks++; if (lsu_state !== 2'd2 || mem.mem_read_valid !== 1'b1 || mem.mem_read_address !== sb[0].addr) begin errors++;
      $display("FAIL load_issue state=%0d vld=%b addr=%h exp 2/1/%h", lsu_state, mem.mem_read_valid, mem.mem_read_address, sb[0].addr); end
    tick(); tick();
    checks++; if (mem.mem_read_valid !== 1'b1 || lsu_state !== 2'd2) begin errors++;
      $display("FAIL load_wait vld=%b state=%0d exp 1/2", mem.mem_read_valid, lsu_state); end
    mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'hA5;
    tick();
    mem.mem_read_ready = 1'b0; mem.mem_read_data = 8'h00;
    e = sb.pop_front();
    checks++; if (lsu_state !== 2'd3 || lsu_out !== e.data || lsu_error !== e.err || mem.mem_read_valid !== 1'b0) begin errors++;
      $display("FAIL load_done state=%0d out=%h err=%b vld=%b exp 3/%h/%b/0", lsu_state, lsu_out, lsu_error, mem.mem_read_valid, e.data, e.err); end
    do_update();
    checks++; if (lsu_state !== 2'd0 || lsu_error !== 1'b0) begin errors++;
      $display("FAIL load_update state=%0d err=%b exp 0/0", lsu_state, lsu_error); end
  endtask

  task automatic test_store_wrap();
    sb.push_back('{addr: 8'hFF, data: 8'h5C, err: 1'b0});
    issue(1'b0, 1'b1, 8'h01, 4'hE, 8'h5C);
    tick();
    checks++; if (mem.mem_write_valid !== 1'b1 || mem.mem_write_address !== sb[0].addr ||
                  mem.mem_write_data !== sb[0].data || mem.mem_read_valid !== 1'b0) begin errors++;
      $display("FAIL store_issue vld=%b addr=%h dat=%h rvld=%b exp 1/%h/%h/0", mem.mem_write_valid,
               mem.mem_write_address, mem.mem_write_data, mem.mem_read_valid, sb[0].addr, sb[0].data); end
    // Ready on the unused read channel must not complete a store.
    mem.mem_read_ready = 1'b1;
    tick();
    mem.mem_read_ready = 1'b0;
    checks++; if (lsu_state !== 2'd2 || mem.mem_write_valid !== 1'b1) begin errors++;
      $display("FAIL store_wrong_ready state=%0d vld=%b exp 2/1", lsu_state, mem.mem_write_valid); end
    mem.mem_write_ready = 1'b1;
    tick();
    mem.mem_write_ready = 1'b0;
    e = sb.pop_front();
    checks++; if (lsu_state !== 2'd3 || mem.mem_write_valid !== 1'b0 || lsu_error !== e.err || lsu_out !== 8'hA5) begin errors++;
      $display("FAIL store_done state=%0d vld=%b err=%b out=%h exp 3/0/%b/a5", lsu_state, mem.mem_write_valid, lsu_error, lsu_out, e.err); end
    do_update();
  endtask

  task automatic test_timeout();
    sb.push_back('{addr: 8'h20, data: 8'hA5, err: 1'b1});
    issue(1'b1, 1'b0, 8'h20, 4'h0, 8'h00);
    tick();
    for (int k = 0; k < 3; k++) tick();
    checks++; if (lsu_state !== 2'd2 || mem.mem_read_valid !== 1'b1) begin errors++;
      $display("FAIL timeout_early state=%0d vld=%b exp 2/1", lsu_state, mem.mem_read_valid); end
    tick();
    e = sb.pop_front();
    checks++; if (lsu_state !== 2'd3 || mem.mem_read_valid !== 1'b0 || lsu_error !== e.err || lsu_out !== e.data) begin errors++;
      $display("FAIL timeout_fire state=%0d vld=%b err=%b out=%h exp 3/0/%b/%h", lsu_state, mem.mem_read_valid, lsu_error, lsu_out, e.err, e.data); end
    do_update();
    checks++; if (lsu_error !== 1'b0) begin errors++; $display("FAIL timeout_clear err=%b exp 0", lsu_error); end

    sb.push_back('{addr: 8'h20, data: 8'h3C, err: 1'b0});
    issue(1'b1, 1'b0, 8'h20, 4'h0, 8'h00);
    tick();
    for (int k = 0; k < 3; k++) tick();
    mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'h3C;
    tick();
    mem.mem_read_ready = 1'b0;
    e = sb.pop_front();
    checks++; if (lsu_state !== 2'd3 || lsu_error !== e.err || lsu_out !== e.data) begin errors++;
      $display("FAIL timeout_ready_wins state=%0d err=%b out=%h exp 3/%b/%h", lsu_state, lsu_error, lsu_out, e.err, e.data); end
    do_update();
  endtask

  task automatic test_both_enables();
    issue(1'b1, 1'b1, 8'h44, 4'h1, 8'h99);
    checks++; if (lsu_state !== 2'd3 || lsu_error !== 1'b1) begin errors++;
      $display("FAIL both_done state=%0d err=%b exp 3/1", lsu_state, lsu_error); end
    tick();
    checks++; if ({mem.mem_read_valid, mem.mem_write_valid} !== 2'b00 || lsu_state !== 2'd3) begin errors++;
      $display("FAIL both_no_req valids=%b state=%0d exp 00/3", {mem.mem_read_valid, mem.mem_write_valid}, lsu_state); end
    do_update();
    checks++; if (lsu_state !== 2'd0 || lsu_error !== 1'b0) begin errors++;
      $display("FAIL both_update state=%0d err=%b exp 0/0", lsu_state, lsu_error); end
  endtask

  task automatic test_enable_freeze();
    sb.push_back('{addr: 8'h41, data: 8'h77, err: 1'b0});
    issue(1'b1, 1'b0, 8'h40, 4'h1, 8'h00);
    tick();
    enable = 1'b0;
    mem.mem_read_ready = 1'b1; mem.mem_read_data = 8'h77;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (lsu_state !== 2'd2 || mem.mem_read_valid !== 1'b1 || lsu_out !== 8'h3C) begin errors++;
        $display("FAIL freeze_%0d state=%0d vld=%b out=%h exp 2/1/3c", k, lsu_state, mem.mem_read_valid, lsu_out); end
    end
    enable = 1'b1;
    tick();
    mem.mem_read_ready = 1'b0;
    e = sb.pop_front();
    checks++; if (lsu_state !== 2'd3 || lsu_out !== e.data || lsu_error !== e.err) begin errors++;
      $display("FAIL freeze_resume state=%0d out=%h err=%b exp 3/%h/%b", lsu_state, lsu_out, lsu_error, e.data, e.err); end
    do_update();
  endtask

  task automatic test_reset_waiting();
    issue(1'b1, 1'b0, 8'h50, 4'h0, 8'h00);
    tick();
    checks++; if (mem.mem_read_valid !== 1'b1) begin errors++; $display("FAIL rstw_pre vld=%b exp 1", mem.mem_read_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (lsu_state !== 2'd0 || mem.mem_read_valid !== 1'b0 || lsu_out !== 8'h00 || lsu_error !== 1'b0) begin errors++;
      $display("FAIL rstw state=%0d vld=%b out=%h err=%b exp 0/0/00/0", lsu_state, mem.mem_read_valid, lsu_out, lsu_error); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a_rs [3];
    logic [3:0] a_imm[3];
    logic [7:0] a_exp[3];
    a_rs[0] = 8'hFF; a_imm[0] = 4'h7; a_exp[0] = 8'h06;
    a_rs[1] = 8'h80; a_imm[1] = 4'h8; a_exp[1] = 8'h78;
    a_rs[2] = 8'h00; a_imm[2] = 4'hF; a_exp[2] = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      sb.push_back('{addr: a_exp[n], data: a_exp[n] ^ 8'h5A, err: 1'b0});
      issue(1'b1, 1'b0, a_rs[n], a_imm[n], 8'h00);
      tick();
      checks++; if (mem.mem_read_address !== sb[0].addr) begin errors++;
        $display("FAIL b2b_addr_%0d got=%h exp=%h", n, mem.mem_read_address, sb[0].addr); end
      mem.mem_read_ready = 1'b1; mem.mem_read_data = mem.mem_read_address ^ 8'h5A;
      tick();
      mem.mem_read_ready = 1'b0;
      e = sb.pop_front();
      checks++; if (lsu_state !== 2'd3 || lsu_out !== e.data) begin errors++;
        $display("FAIL b2b_done_%0d state=%0d out=%h exp 3/%h", n, lsu_state, lsu_out, e.data); end
      do_update();
    end
  endtask

  initial begin
    mem.mem_read_ready  = 1'b0;
    mem.mem_read_data   = 8'h00;
    mem.mem_write_ready = 1'b0;
    test_reset();
    test_load();
    test_store_wrap();
    test_timeout();
    test_both_enables();
    test_enable_freeze();
    test_back_to_back();
    test_reset_waiting();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_param.md
# lsu_param

Parametrised load-store unit, the per-thread memory access block in each core. Executes LDR and STR against the data-memory channel using a valid/ready handshake. Adds configurable address and data widths, an immediate-offset address (rs + imm) and a bounded wait with timeout error reporting. One instance per thread lane.

## Interface

- ADDR_BITS, 8, memory address width.
- DATA_BITS, 8, memory data width.
- IMM_BITS, 4, width of the signed address offset.
- TIMEOUT_CYCLES, 255, maximum number of WAITING cycles without ready; 0 disables the timeout.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  lane active; low freezes all state and outputs.
- core_state  in  3  core phase; REQUEST = 3'b011, UPDATE = 3'b110.
- decoded_mem_read_enable  in  1  LDR decoded.
- decoded_mem_write_enable  in  1  STR decoded.
- rs  in  ADDR_BITS  base address.
- imm  in  IMM_BITS  signed offset, two's complement.
- rt  in  DATA_BITS  store data.
- mem_read_valid  out  1  read request.
- mem_read_address  out  ADDR_BITS  read address.
- mem_read_ready  in  1  read response valid.
- mem_read_data  in  DATA_BITS  read response data.
- mem_write_valid  out  1  write request.
- mem_write_address  out  ADDR_BITS  write address.
- mem_write_data  out  DATA_BITS  write data.
- mem_write_ready  in  1  write accepted.
- lsu_state  out  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
- lsu_out  out  DATA_BITS  last loaded data.
- lsu_error  out  1  last operation failed; meaningful in DONE.

## Operation

- Reset: lsu_state=IDLE, lsu_out=0, lsu_error=0, both valids 0, addresses and write data 0.
- enable=0: no transitions, no counter advance, all registers hold. A valid already asserted stays asserted.
- IDLE: if core_state==REQUEST and exactly one of read/write enable is set, latch the operation type and go to REQUESTING. If both are set, go directly to DONE with lsu_error=1 and issue no request. If neither is set, stay.
- REQUESTING: compute addr = rs + sign_extend(imm), modulo 2^ADDR_BITS (wrap-around, no error). For a load, drive mem_read_valid=1 and mem_read_address=addr. For a store, drive mem_write_valid=1, mem_write_address=addr and mem_write_data=rt. Clear the wait counter and go to WAITING.
- WAITING, load: if mem_read_ready, capture lsu_out=mem_read_data, drop valid and go to DONE.
- WAITING, store: if mem_write_ready, drop valid and go to DONE.
- WAITING, no ready: increment the counter. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES, drop valid, set lsu_error=1 and go to DONE. lsu_out is unchanged on timeout.
- Ready and timeout on the same edge: ready wins, with no error.
- DONE: hold until core_state==UPDATE, then go to IDLE and clear lsu_error.
- Only the latched operation type steers WAITING. Changes in the decoded enables after IDLE are ignored.
- Ready on the channel not in use, or outside WAITING, is ignored.

## Timing

- REQUEST sampled at edge E0 → REQUESTING after E0 → WAITING with valid=1 after E1.
- Ready high at edge E2 → DONE and lsu_out valid after E2. Minimum load/store latency is 3 edges from the REQUEST sample to DONE.
- Valid is high exactly from after E1 until after the ready (or timeout) edge.
- Counter width is clog2(TIMEOUT_CYCLES+1). The timeout fires on the TIMEOUT_CYCLES-th consecutive WAITING edge without ready.
- Reset in any state returns to IDLE on the next edge and deasserts valid immediately in the registered outputs. An in-flight request is abandoned.

## Test plan

- Load: rs=8'h10, imm=4'h3, REQUEST; ready after 2 cycles with data 8'hA5 → read address 8'h13, lsu_out=8'hA5, state DONE, error 0, IDLE after UPDATE.
- Store with negative offset and wrap: rs=8'h01, imm=4'hE (−2), rt=8'h5C → write address 8'hFF, data 8'h5C, valid high until write_ready, then DONE.
- Timeout: TIMEOUT_CYCLES=4, load with no ready → valid drops after the 4th WAITING edge, lsu_error=1, lsu_out unchanged. Repeat with ready on the 4th edge → success, error 0.
- Both enables set at REQUEST → DONE next cycle, lsu_error=1, no valid ever asserted; UPDATE returns to IDLE with error 0.
- enable dropped for 5 cycles during WAITING with ready high → state frozen, no capture; completes after enable returns.
- Reset asserted during WAITING with valid high → next cycle IDLE, valids 0, lsu_out=0, lsu_error=0.
